alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- ID/EX issue register that drives the execute-stage ALU interface (EALUC, EXA, EXB).
- Decodes the MIPS instruction word held in ID and encodes the 4-bit ALU operation code.
- Forms the operands, including the shift-amount and LUI packing the ALU expects, and registers everything into EX with stall/flush control.

Parameters:
- BUBBLE_ALUC, 4'b0010, EALUC value driven during reset, bubbles and illegal instructions.
- TRACE, 0, when 1 emit one $display line per issued instruction (simulation only).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- DINST  input  32  instruction word from ID.
- DVALID  input  1  DINST/DRA/DRB valid this cycle.
- DRA  input  32  rs register value (already forwarded).
- DRB  input  32  rt register value (already forwarded).
- ESTALL  input  1  hold EX register contents.
- EFLUSH  input  1  replace EX contents with a bubble.
- EALUC  output  4  ALU operation code.
- EXA  output  32  ALU operand A.
- EXB  output  32  ALU operand B.
- EWN  output  5  destination register number.
- EWREG  output  1  register write enable.
- EVALID  output  1  EX slot holds a real instruction.
- EILLEGAL  output  1  EX slot holds an undecodable instruction (one slot).
- ESTICKY  output  1  an illegal instruction has been issued since reset.

Behaviour:
- Reset: on any rising edge with RST=1, the EX register takes the bubble value and ESTICKY=0.
  - Bubble value: EVALID=0, EWREG=0, EILLEGAL=0, EALUC=BUBBLE_ALUC, EXA=0, EXB=0, EWN=0.
- Edge priority: RST > EFLUSH > ESTALL > load.
  - EFLUSH=1: load the bubble value. EFLUSH wins over a simultaneous ESTALL.
  - ESTALL=1 (no flush): every output holds its value, including EILLEGAL.
  - Otherwise, DVALID=1: load the decoded instruction with EVALID=1. DVALID=0: load the bubble value.
- Latency: exactly 1 cycle from ID inputs to EX outputs. The block has no combinational path from inputs to outputs.
- Fields: op=DINST[31:26], funct=DINST[5:0], rt=DINST[20:16], rd=DINST[15:11], sh=DINST[10:6], imm=DINST[15:0].
  - SE = sign-extended imm; ZE = zero-extended imm.
- R-type (op=000000): EXA=DRA, EXB=DRB, EWN=rd. funct to EALUC:
  - add 100000 -> 0010; addu 100001 -> 0011; sub 100010 -> 0110; subu 100011 -> 1110.
  - and 100100 -> 0000; or 100101 -> 0001; xor 100110 -> 1100.
  - slt 101010 -> 0111; sltu 101011 -> 0101.
- Shifts (op=000000): EXA=DRB, EXB={21'b0,sh,6'b0}, EWN=rd.
  - sll 000000 -> 1000; srl 000010 -> 1001.
- I-type: EXA=DRA, EWN=rt. op to EALUC and EXB:
  - addi 001000 -> 0010 SE; addiu 001001 -> 0011 SE.
  - slti 001010 -> 0111 SE; sltiu 001011 -> 0101 SE.
  - andi 001100 -> 0000 ZE; ori 001101 -> 0001 ZE; xori 001110 -> 1100 ZE.
  - lui 001111 -> 1111, EXA=0, EXB=ZE.
- EWREG=1 for every decoded instruction except when EWN=0. Writes to $0 are suppressed, so sll $0,$0,0 (NOP) issues with EVALID=1, EWREG=0.
- Any other op/funct is illegal. It loads EVALID=1, EILLEGAL=1, EWREG=0, EALUC=BUBBLE_ALUC, EXA=0, EXB=0, EWN=0, and sets ESTICKY.
- ESTICKY sets on the load edge of an illegal instruction. A flushed or stalled-out input never sets it. It clears only on RST.
- Reset asserted mid-stall or mid-flush: the reset value wins on that edge.
- TRACE=1: a $display line with EALUC, EXA, EXB, EWN on each load with EVALID=1.

Test Plan:
- RST=1 for 2 cycles, then ESTALL=0, DVALID=0 -> all outputs are the bubble value, EALUC=0010, ESTICKY=0.
- DINST=0x00851020 (add $2,$4,$5), DRA=7, DRB=5 -> next cycle EALUC=0010, EXA=7, EXB=5, EWN=2, EWREG=1, EVALID=1.
- DINST=0x00041100 (sll $2,$4,4), DRB=0x3 -> EALUC=1000, EXA=3, EXB=0x100 (EXB[10:6]=4); then DINST=0x3C021234 (lui $2,0x1234) -> EALUC=1111, EXB=0x00001234, EXA=0.
- addi with imm=0xFFFF -> EXB=0xFFFFFFFF; ori with imm=0xFFFF -> EXB=0x0000FFFF.
- Load add, assert ESTALL for 3 cycles while DINST changes -> outputs unchanged. Then assert ESTALL and EFLUSH together -> bubble on the next edge.
- DINST=0xFC000000 (illegal) -> EVALID=1, EILLEGAL=1, EWREG=0 for one slot; ESTICKY stays 1 afterwards until RST. Illegal input with EFLUSH=1 -> ESTICKY stays 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// ID/EX issue register in front of the execute-stage ALU. It decodes the MIPS
// instruction held in ID into a 4-bit ALU operation code and forms the two
// ALU operands, including shift-amount placement and LUI packing. The result
// is captured into the EX register under reset/flush/stall control.
//
// Ports
//   CLK      in   1   clock, all state updates on the rising edge
//   RST      in   1   synchronous reset, active-high
//   DINST    in  32   instruction word from ID
//   DVALID   in   1   DINST/DRA/DRB valid this cycle
//   DRA      in  32   rs register value (already forwarded)
//   DRB      in  32   rt register value (already forwarded)
//   ESTALL   in   1   hold EX register contents
//   EFLUSH   in   1   replace EX contents with a bubble
//   EALUC    out  4   ALU operation code
//   EXA      out 32   ALU operand A
//   EXB      out 32   ALU operand B
//   EWN      out  5   destination register number
//   EWREG    out  1   register write enable
//   EVALID   out  1   EX slot holds a real instruction
//   EILLEGAL out  1   EX slot holds an undecodable instruction
//   ESTICKY  out  1   an illegal instruction has issued since reset
module alu_issue_stage #(
  parameter logic [3:0] BUBBLE_ALUC = 4'b0010,
  parameter bit         TRACE       = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DINST,
  input  logic        DVALID,
  input  logic [31:0] DRA,
  input  logic [31:0] DRB,
  input  logic        ESTALL,
  input  logic        EFLUSH,
  output logic [3:0]  EALUC,
  output logic [31:0] EXA,
  output logic [31:0] EXB,
  output logic [4:0]  EWN,
  output logic        EWREG,
  output logic        EVALID,
  output logic        EILLEGAL,
  output logic        ESTICKY
);

  // Instruction fields
  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [4:0]  sh_s;
  logic [31:0] se_s;
  logic [31:0] ze_s;

  assign op_s    = DINST[31:26];
  assign funct_s = DINST[5:0];
  assign rt_s    = DINST[20:16];
  assign rd_s    = DINST[15:11];
  assign sh_s    = DINST[10:6];
  assign se_s    = {{16{DINST[15]}}, DINST[15:0]};
  assign ze_s    = {16'h0000, DINST[15:0]};

  // Decoded values for the instruction currently in ID
  logic [3:0]  dec_aluc_s;
  logic [31:0] dec_a_s;
  logic [31:0] dec_b_s;
  logic [4:0]  dec_wn_s;
  logic        dec_illegal_s;
  logic        dec_wreg_s;

  // EX register
  logic [3:0]  ealuc_r;
  logic [31:0] exa_r;
  logic [31:0] exb_r;
  logic [4:0]  ewn_r;
  logic        ewreg_r;
  logic        evalid_r;
  logic        eillegal_r;
  logic        esticky_r;

  // Decode op/funct into ALU code, operands and destination.
  // Anything not recognised falls through as illegal with bubble-like fields.
  always_comb begin
    dec_aluc_s    = BUBBLE_ALUC;
    dec_a_s       = 32'h0000_0000;
    dec_b_s       = 32'h0000_0000;
    dec_wn_s      = 5'd0;
    dec_illegal_s = 1'b1;
    case (op_s)
      6'b000000: begin
        case (funct_s)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b101010, 6'b101011: begin
            dec_a_s       = DRA;
            dec_b_s       = DRB;
            dec_wn_s      = rd_s;
            dec_illegal_s = 1'b0;
            case (funct_s)
              6'b100000: dec_aluc_s = 4'b0010;
              6'b100001: dec_aluc_s = 4'b0011;
              6'b100010: dec_aluc_s = 4'b0110;
              6'b100011: dec_aluc_s = 4'b1110;
              6'b100100: dec_aluc_s = 4'b0000;
              6'b100101: dec_aluc_s = 4'b0001;
              6'b100110: dec_aluc_s = 4'b1100;
              6'b101010: dec_aluc_s = 4'b0111;
              6'b101011: dec_aluc_s = 4'b0101;
              default:   dec_aluc_s = BUBBLE_ALUC;
            endcase
          end
          // Shifts: the ALU shifts operand A by the amount sitting in EXB[10:6]
          6'b000000, 6'b000010: begin
            dec_a_s       = DRB;
            dec_b_s       = {21'd0, sh_s, 6'd0};
            dec_wn_s      = rd_s;
            dec_illegal_s = 1'b0;
            dec_aluc_s    = funct_s[1] ? 4'b1001 : 4'b1000;
          end
          default: dec_illegal_s = 1'b1;
        endcase
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
        dec_a_s       = DRA;
        dec_b_s       = se_s;
        dec_wn_s      = rt_s;
        dec_illegal_s = 1'b0;
        case (op_s[1:0])
          2'b00:   dec_aluc_s = 4'b0010;
          2'b01:   dec_aluc_s = 4'b0011;
          2'b10:   dec_aluc_s = 4'b0111;
          2'b11:   dec_aluc_s = 4'b0101;
          default: dec_aluc_s = BUBBLE_ALUC;
        endcase
      end
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec_b_s       = ze_s;
        dec_wn_s      = rt_s;
        dec_illegal_s = 1'b0;
        // LUI: the ALU does the 16-bit left shift itself, so A is forced to 0
        if (op_s[1:0] == 2'b11) begin
          dec_a_s = 32'h0000_0000;
        end else begin
          dec_a_s = DRA;
        end
        case (op_s[1:0])
          2'b00:   dec_aluc_s = 4'b0000;
          2'b01:   dec_aluc_s = 4'b0001;
          2'b10:   dec_aluc_s = 4'b1100;
          2'b11:   dec_aluc_s = 4'b1111;
          default: dec_aluc_s = BUBBLE_ALUC;
        endcase
      end
      default: dec_illegal_s = 1'b1;
    endcase
  end

  // Writes to $0 are dropped here so the writeback stage never sees them
  assign dec_wreg_s = ~dec_illegal_s & (dec_wn_s != 5'd0);

  // EX register update: reset, then flush, then stall, then load
  always_ff @(posedge CLK) begin
    if (RST || EFLUSH || (!ESTALL && !DVALID)) begin
      ealuc_r    <= BUBBLE_ALUC;
      exa_r      <= 32'h0000_0000;
      exb_r      <= 32'h0000_0000;
      ewn_r      <= 5'd0;
      ewreg_r    <= 1'b0;
      evalid_r   <= 1'b0;
      eillegal_r <= 1'b0;
    end else if (ESTALL) begin
      ealuc_r    <= ealuc_r;
      exa_r      <= exa_r;
      exb_r      <= exb_r;
      ewn_r      <= ewn_r;
      ewreg_r    <= ewreg_r;
      evalid_r   <= evalid_r;
      eillegal_r <= eillegal_r;
    end else begin
      ealuc_r    <= dec_aluc_s;
      exa_r      <= dec_a_s;
      exb_r      <= dec_b_s;
      ewn_r      <= dec_wn_s;
      ewreg_r    <= dec_wreg_s;
      evalid_r   <= 1'b1;
      eillegal_r <= dec_illegal_s;
    end
  end

  // Sticky illegal flag: set only when an illegal instruction actually loads
  always_ff @(posedge CLK) begin
    if (RST) begin
      esticky_r <= 1'b0;
    end else if (!EFLUSH && !ESTALL && DVALID && dec_illegal_s) begin
      esticky_r <= 1'b1;
    end else begin
      esticky_r <= esticky_r;
    end
  end

`ifndef SYNTHESIS
  generate
    if (TRACE) begin : g_trace
      // Print one line per instruction loaded into EX
      always_ff @(posedge CLK) begin
        if (!RST && !EFLUSH && !ESTALL && DVALID) begin
          $display("issue aluc=%b exa=%h exb=%h ewn=%0d",
                   dec_aluc_s, dec_a_s, dec_b_s, dec_wn_s);
        end
      end
    end
  endgenerate
`endif

  assign EALUC    = ealuc_r;
  assign EXA      = exa_r;
  assign EXB      = exb_r;
  assign EWN      = ewn_r;
  assign EWREG    = ewreg_r;
  assign EVALID   = evalid_r;
  assign EILLEGAL = eillegal_r;
  assign ESTICKY  = esticky_r;

endmodule
